// File: rtl/fetch_queue.sv
// Dual-issue fetch stage: owns the fetch PC, captures two sequential words per
// cycle into a circular {pc, instr} queue and presents the two oldest to decode.
module fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rd0,
  input  logic [31:0]              imem_rd1,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic [1:0]               deq_count,
  output logic                     valid0,
  output logic [31:0]              instr0,
  output logic [31:0]              pc0,
  output logic                     valid1,
  output logic [31:0]              instr1,
  output logic [31:0]              pc1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [CW-1:0]   free_slots;
  logic [1:0]      deq_req;
  logic [CW-1:0]   eff_deq;
  logic [1:0]      enq_n;
  logic            we0, we1;
  logic [AW-1:0]   wr_ptr1, rd_ptr1;
  logic            redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Handshake: valid0/valid1 advertise the two oldest entries; decode consumes
  // deq_count of them (clamped to what is valid) on the next rising edge.
  // Enqueue space is judged on pre-edge occupancy, so a same-cycle dequeue
  // never makes room for that cycle's fetch.
  always_comb begin
    free_slots = CW'(DEPTH) - count_q;
    deq_req    = (deq_count == 2'd3) ? 2'd2 : deq_count;
    eff_deq    = (CW'(deq_req) > count_q) ? count_q : CW'(deq_req);
    enq_n      = 2'd0;
    we0        = 1'b0;
    we1        = 1'b0;
    if (!fetch_pc_q[2]) begin
      if (free_slots >= CW'(2)) begin
        enq_n = 2'd2;
        we0   = 1'b1;
        we1   = 1'b1;
      end
    end else if (free_slots >= CW'(1)) begin
      enq_n = 2'd1;
      we0   = 1'b1;
    end
    fetch_pc_d = fetch_pc_q + (32'(enq_n) << 2);
    wr_ptr_d   = wr_ptr_q + AW'(enq_n);
    rd_ptr_d   = rd_ptr_q + AW'(eff_deq);
    count_d    = count_q + CW'(enq_n) - eff_deq;
    // Redirect flushes everything, including words fetched this cycle.
    if (redirect_valid) begin
      we0        = 1'b0;
      we1        = 1'b0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  assign wr_ptr1 = wr_ptr_q + AW'(1);

  // Storage is not reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (we0) mem_q[wr_ptr_q] <= '{pc: fetch_pc_q, instr: imem_rd0};
    if (we1) mem_q[wr_ptr1]  <= '{pc: fetch_pc_q + 32'd4, instr: imem_rd1};
  end

  assign rd_ptr1   = rd_ptr_q + AW'(1);
  assign imem_addr = fetch_pc_q;
  assign count     = count_q;
  assign valid0    = (count_q != '0);
  assign valid1    = (count_q >= CW'(2));
  assign instr0    = valid0 ? mem_q[rd_ptr_q].instr : NOP;
  assign pc0       = valid0 ? mem_q[rd_ptr_q].pc    : 32'd0;
  assign instr1    = valid1 ? mem_q[rd_ptr1].instr  : NOP;
  assign pc1       = valid1 ? mem_q[rd_ptr1].pc     : 32'd0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: hand-computed occupancy/PC checks plus a
// scoreboard that verifies every entry decode consumes, in order.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   imem_addr, imem_rd0, imem_rd1;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'd0;
  logic [1:0]    deq_count = 2'd0;
  logic          valid0, valid1;
  logic [31:0]   instr0, pc0, instr1, pc1;
  logic [CW-1:0] count;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [63:0]   exp_q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr),
    .imem_rd0(imem_rd0), .imem_rd1(imem_rd1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_count(deq_count),
    .valid0(valid0), .instr0(instr0), .pc0(pc0),
    .valid1(valid1), .instr1(instr1), .pc1(pc1),
    .count(count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Memory model: word[i] = 0x1000 + i
  assign imem_rd0 = 32'h1000 + (imem_addr >> 2);
  assign imem_rd1 = 32'h1000 + (imem_addr >> 2) + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected fetch stream from a start PC; replaces whatever was pending.
  task automatic push_stream(input logic [31:0] start_pc);
    logic [31:0] p;
    exp_q.delete();
    p = start_pc;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({p, 32'h1000 + (p >> 2)});
      p = p + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] deq, input logic rv, input logic [31:0] rpc);
    deq_count      = deq;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  // Scoreboard monitor
  task automatic pop_cmp(input string name, input logic [63:0] act);
    logic [63:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: consumed pc=0x%08h instr=0x%08h with empty expected queue",
               name, act[63:32], act[31:0]);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got pc=0x%08h instr=0x%08h expected pc=0x%08h instr=0x%08h",
                 name, act[63:32], act[31:0], e[63:32], e[31:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    int n;
    if (reset && !redirect_valid) begin
      n = (deq_count == 2'd3) ? 2 : int'(deq_count);
      if (n >= 1 && valid0) pop_cmp("sb_slot0", {pc0, instr0});
      if (n >= 2 && valid1) pop_cmp("sb_slot1", {pc1, instr1});
    end
  end

  // Directed sequence
  initial begin
    push_stream(32'h0);
    #2;
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_valid0", 32'(valid0), 32'd0);
    chk("rst_valid1", 32'(valid1), 32'd0);
    chk("rst_instr0", instr0, 32'h13);
    chk("rst_instr1", instr1, 32'h13);
    chk("rst_pc0", pc0, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    #10 reset = 1'b1;

    tick();
    chk("e1_count", 32'(count), 32'd2);
    chk("e1_instr0", instr0, 32'h1000);
    chk("e1_pc0", pc0, 32'h0);
    chk("e1_instr1", instr1, 32'h1001);
    chk("e1_pc1", pc1, 32'h4);
    chk("e1_imem_addr", imem_addr, 32'h8);

    tick(); tick(); tick();
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_imem_addr", imem_addr, 32'h20);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_count", 32'(count), 32'd8);
      chk("full_imem_addr", imem_addr, 32'h20);
      chk("full_pc0", pc0, 32'h0);
      chk("full_instr0", instr0, 32'h1000);
    end

    drive(2'd2, 1'b0, 32'h0);
    tick();
    chk("deq_full_count", 32'(count), 32'd6);
    chk("deq_full_imem_addr", imem_addr, 32'h20);
    chk("deq_full_pc0", pc0, 32'h8);
    drive(2'd3, 1'b0, 32'h0);
    tick();
    chk("deq3_count", 32'(count), 32'd6);
    chk("deq3_imem_addr", imem_addr, 32'h28);
    chk("deq3_pc0", pc0, 32'h10);

    drive(2'd2, 1'b1, 32'h106);
    push_stream(32'h104);
    tick();
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_imem_addr", imem_addr, 32'h104);
    chk("redir_valid0", 32'(valid0), 32'd0);
    chk("redir_instr0", instr0, 32'h13);
    drive(2'd0, 1'b0, 32'h0);
    tick();
    chk("redir1_count", 32'(count), 32'd1);
    chk("redir1_pc0", pc0, 32'h104);
    chk("redir1_instr0", instr0, 32'h1041);
    chk("redir1_imem_addr", imem_addr, 32'h108);
    chk("redir1_valid1", 32'(valid1), 32'd0);
    chk("redir1_instr1", instr1, 32'h13);
    chk("redir1_pc1", pc1, 32'h0);
    tick();
    chk("redir2_count", 32'(count), 32'd3);
    chk("redir2_pc1", pc1, 32'h108);
    chk("redir2_instr1", instr1, 32'h1042);
    chk("redir2_imem_addr", imem_addr, 32'h110);

    drive(2'd1, 1'b1, 32'h204);
    push_stream(32'h204);
    tick();
    chk("r204_count", 32'(count), 32'd0);
    chk("r204_imem_addr", imem_addr, 32'h204);
    drive(2'd0, 1'b0, 32'h0);
    tick();
    chk("r204b_count", 32'(count), 32'd1);
    chk("r204b_pc0", pc0, 32'h204);
    drive(2'd2, 1'b0, 32'h0);
    tick();
    chk("overdeq_count", 32'(count), 32'd2);
    chk("overdeq_pc0", pc0, 32'h208);
    chk("overdeq_pc1", pc1, 32'h20c);
    chk("overdeq_imem_addr", imem_addr, 32'h210);
    drive(2'd3, 1'b0, 32'h0);
    tick();
    chk("deq3b_count", 32'(count), 32'd2);
    chk("deq3b_pc0", pc0, 32'h210);
    chk("deq3b_imem_addr", imem_addr, 32'h218);

    drive(2'd2, 1'b0, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("steady_count", 32'(count), 32'd2);
      chk("steady_pc0", pc0, 32'h210 + 32'(8 * k));
    end
    chk("steady_imem_addr", imem_addr, 32'h2b8);

    drive(2'd0, 1'b1, 32'h304);
    push_stream(32'h304);
    tick();
    drive(2'd0, 1'b0, 32'h0);
    tick(); tick(); tick();
    chk("pre_areset_count", 32'(count), 32'd5);
    chk("pre_areset_imem_addr", imem_addr, 32'h318);
    #2 reset = 1'b0;
    push_stream(32'h0);
    #1;
    chk("areset_valid0", 32'(valid0), 32'd0);
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_imem_addr", imem_addr, 32'h0);
    chk("areset_instr0", instr0, 32'h13);
    #2 reset = 1'b1;
    tick();
    chk("resume_count", 32'(count), 32'd2);
    chk("resume_pc0", pc0, 32'h0);
    chk("resume_instr0", instr0, 32'h1000);
    chk("resume_imem_addr", imem_addr, 32'h8);
    drive(2'd2, 1'b0, 32'h0);
    tick(); tick(); tick();
    drive(2'd0, 1'b0, 32'h0);
    tick();
    chk("final_count", 32'(count), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Dual-issue instruction fetch stage with prefetch buffer; sits directly upstream of decode/Control_Unit.
- Owns the fetch PC and drives the combinational Instruction_Memory address.
- Captures two sequential words per cycle into a circular queue of {PC, instruction} entries.
- Presents the two oldest entries to the superscalar decode slots. Flushes on branch/jump redirect from execute.

Parameters:
- DEPTH, 8: queue entries; power of two, minimum 4.
- RESET_PC, 32'h0000_0000: fetch PC after reset.
- NOP, 32'h0000_0013: instruction driven on an invalid output slot (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_addr  out  32  current fetch PC to instruction memory.
- imem_rd0  in  32  word at imem_addr; combinational from memory.
- imem_rd1  in  32  word at imem_addr+4; combinational from memory.
- redirect_valid  in  1  taken branch/jump from execute this cycle.
- redirect_pc  in  32  target PC; bits [1:0] ignored (treated as 0).
- deq_count  in  2  entries consumed by decode this cycle (0, 1 or 2).
- valid0  out  1  slot 0 holds a valid entry.
- instr0  out  32  oldest instruction.
- pc0  out  32  PC of instr0.
- valid1  out  1  slot 1 holds a valid entry.
- instr1  out  32  second-oldest instruction.
- pc1  out  32  PC of instr1.
- count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, reset=0):
  - fetch_pc=RESET_PC; rd_ptr=wr_ptr=0; count=0.
  - valid0=valid1=0; instr0=instr1=NOP; pc0=pc1=0.
  - Queue contents are don't-care.
  - Reset asserted mid-operation discards all entries immediately, with no wait for a clock edge.
- Outputs are combinational from queue state only; imem_rd* never reaches the outputs in the same cycle.
  - valid0 = count>=1; valid1 = count>=2.
  - instr/pc of an invalid slot = NOP/0.
- Slot order: slot0 = entry at rd_ptr; slot1 = entry at rd_ptr+1 (mod DEPTH).
- Dequeue:
  - eff_deq = min(deq_count, count); deq_count=3 is treated as 2.
  - rd_ptr += eff_deq (mod DEPTH).
- Enqueue, evaluated on pre-edge count; same-cycle dequeue does not free space:
  - Aligned fetch_pc (bit2=0) and DEPTH-count>=2: write {fetch_pc,imem_rd0}, {fetch_pc+4,imem_rd1}; wr_ptr+=2; fetch_pc+=8.
  - Misaligned fetch_pc (bit2=1) and DEPTH-count>=1: write {fetch_pc,imem_rd0} only; wr_ptr+=1; fetch_pc+=4. This realigns to an 8-byte boundary.
  - Otherwise no write; fetch_pc holds.
- Count update: count_next = count + enq - eff_deq. Enqueue and dequeue in the same cycle are legal.
- Pointer and PC wrap:
  - Pointers wrap mod DEPTH.
  - fetch_pc wraps mod 2^32 (0xFFFF_FFF8+8 -> 0).
- Redirect (redirect_valid=1) overrides everything that cycle:
  - Next state: count=0, rd_ptr=wr_ptr=0, fetch_pc={redirect_pc[31:2],2'b00}.
  - No enqueue, dequeue ignored.
  - imem_rd* in the redirect cycle are discarded.
- Latency:
  - A word fetched on edge N is first visible on instr0/instr1 after edge N.
  - After a redirect edge, the target is fetched in the following cycle and appears valid after the next edge: 2 edges redirect-to-valid.
- Full and empty:
  - count never exceeds DEPTH.
  - When full, imem_addr is stable until space opens.
  - When empty, valid0=valid1=0.

Test Plan:
- Reset low then high, memory word[i]=0x1000+i:
  - Before first edge: imem_addr=0, valid0=0, instr0=0x13.
  - After edge 1: count=2, instr0=0x1000, pc0=0, instr1=0x1001, pc1=4, imem_addr=8.
- Fill with deq_count=0, DEPTH=8:
  - After 4 edges: count=8, imem_addr=0x20.
  - 3 further edges: count=8, imem_addr=0x20, slot0 unchanged.
- Redirect to 0x106 with queue half full:
  - Next edge: count=0, imem_addr=0x104.
  - Then: count=1, pc0=0x104, imem_addr=0x108.
  - Then: count=3, pc1=0x108.
- Steady state deq_count=2 for 20 cycles:
  - count stays 2 after warm-up; pointers wrap past DEPTH.
  - pc0 advances by 8 every cycle with no gaps or duplicates.
- Over-dequeue:
  - count=1, deq_count=2, no space issue: count_next=0+enqueued; no underflow, no pointer skew.
  - deq_count=3 behaves as 2.
- Asynchronous reset pulse between clock edges with count=5:
  - valid0 drops immediately; count=0, imem_addr=RESET_PC.
  - Normal fetch resumes on the first edge after release.
